// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, wrap/saturate
// encodings and the bin-to-Gray conversion used on the next-state path.
package gray_pkg;

   localparam int GRAY_WIDTH_DEF = 3;
   localparam int GRAY_WIDTH_MAX = 16;

   localparam bit WRAP_MODE = 1'b1;
   localparam bit SAT_MODE  = 1'b0;

   // Operates at the maximum width; callers zero-extend and truncate.
   function automatic logic [GRAY_WIDTH_MAX-1:0] bin_to_gray(
      input logic [GRAY_WIDTH_MAX-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter, the mirror of the downstream
// Gray-to-binary stage.
module bin2gray
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = WIDTH'(bin_to_gray(GRAY_WIDTH_MAX'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Loadable Gray-code counter with registered Gray and binary outputs.
// Define GRAY_COUNTER_UPDOWN_EN to add the dir port and down-counting.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH_DEF,
   parameter bit WRAP  = WRAP_MODE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
`ifdef GRAY_COUNTER_UPDOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             tc,
   output logic             wrap_p
);

   localparam bit              SATURATE = (WRAP == SAT_MODE);
   localparam logic [WIDTH-1:0] BIN_MAX = '1;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             up;
   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gray_nxt;
   logic             wrap_nxt;

`ifdef GRAY_COUNTER_UPDOWN_EN
   assign up = dir;
`else
   assign up = 1'b1;
`endif

   assign tc = up ? (bin == BIN_MAX) : (bin == '0);

   // Load outranks counting; the wrap pulse only ever comes from a count step.
   always_comb begin
      bin_nxt  = bin;
      wrap_nxt = 1'b0;
      if (load) begin
         bin_nxt = load_bin;
      end else if (en) begin
         if (!(tc && SATURATE)) begin
            bin_nxt  = up ? (bin + ONE) : (bin - ONE);
            wrap_nxt = tc;
         end
      end
   end

   bin2gray #(
      .WIDTH(WIDTH)
   ) u_bin2gray (
      .bin (bin_nxt),
      .gray(gray_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin    <= '0;
         gray   <= '0;
         wrap_p <= 1'b0;
      end else begin
         bin    <= bin_nxt;
         gray   <= gray_nxt;
         wrap_p <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Directed and random checks of gray_counter in wrap and saturate modes,
// with a Gray-to-binary model standing in for the downstream stage.
module tb_gray_counter;

   localparam int W = 3;
   localparam logic [W-1:0] MAXV = '1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_bin = '0;
   logic         dir = 1'b1;

   logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
   logic         tc_w, wrap_w, tc_s, wrap_s;

   int n_cmp = 0;
   int n_err = 0;

   logic [W:0] exp_q[$];
   logic [W:0] sat_q[$];

   gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_bin(load_bin),
`ifdef GRAY_COUNTER_UPDOWN_EN
      .dir(dir),
`endif
      .gray(gray_w), .bin(bin_w), .tc(tc_w), .wrap_p(wrap_w)
   );

   gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_bin(load_bin),
`ifdef GRAY_COUNTER_UPDOWN_EN
      .dir(dir),
`endif
      .gray(gray_s), .bin(bin_s), .tc(tc_s), .wrap_p(wrap_s)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reference behaviour: returns {wrap pulse, next bin}.
   function automatic logic [W:0] model(input logic [W-1:0] b, input logic e, input logic l,
                                        input logic [W-1:0] lb, input logic up, input logic sat);
      logic         t;
      logic [W-1:0] one;
      one = 1;
      t = up ? (b == MAXV) : (b == '0);
      if (l) return {1'b0, lb};
      if (!e) return {1'b0, b};
      if (t && sat) return {1'b0, b};
      if (t) return {1'b1, (up ? {W{1'b0}} : MAXV)};
      return {1'b0, (up ? b + one : b - one)};
   endfunction

   logic [W-1:0] up_gray[8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

   initial begin : main
      logic [W-1:0] eb_w, eb_s, prev_w, lb;
      logic [W:0]   nx_w, nx_s, got;
      logic         e, l, d, tc_exp;

      do_reset();

      // reset state and full up-count cycle through the wrap
      check("rst_bin", 16'(bin_w), 16'h0);
      check("rst_gray", 16'(gray_w), 16'h0);
      check("rst_tc", 16'(tc_w), 16'h0);
      check("rst_wrap", 16'(wrap_w), 16'h0);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("up_gray", 16'(gray_w), 16'(up_gray[i]));
         check("up_tc", 16'(tc_w), 16'(i == 6));
         check("up_wrap", 16'(wrap_w), 16'(i == 7));
      end
      step();
      check("up9_gray", 16'(gray_w), 16'h1);
      check("up9_wrap", 16'(wrap_w), 16'h0);

      // load beats enable
      load = 1'b1; load_bin = 3'd5;
      step();
      check("ld_bin", 16'(bin_w), 16'h5);
      check("ld_gray", 16'(gray_w), 16'h7);
      check("ld_wrap", 16'(wrap_w), 16'h0);

      // load to terminal raises tc but no pulse
      en = 1'b0; load_bin = 3'd7;
      step();
      check("ldtc_tc", 16'(tc_w), 16'h1);
      check("ldtc_wrap", 16'(wrap_w), 16'h0);
      load = 1'b0; en = 1'b1;
      step();
      check("ldtc_next_bin", 16'(bin_w), 16'h0);
      check("ldtc_next_wrap", 16'(wrap_w), 16'h1);
      en = 1'b0;
      step();
      check("wrap_once", 16'(wrap_w), 16'h0);

      // saturation
      load = 1'b1; load_bin = 3'd7;
      step();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("sat_bin", 16'(bin_s), 16'h7);
         check("sat_gray", 16'(gray_s), 16'h4);
         check("sat_tc", 16'(tc_s), 16'h1);
         check("sat_wrap", 16'(wrap_s), 16'h0);
      end
      en = 1'b0;

      // asynchronous reset mid-count, load ignored while held
      do_reset();
      en = 1'b1;
      step(); step(); step();
      check("mid_pre_bin", 16'(bin_w), 16'h3);
      #3;
      rst = 1'b1;
      #1;
      check("mid_async_bin", 16'(bin_w), 16'h0);
      check("mid_async_gray", 16'(gray_w), 16'h0);
      check("mid_async_wrap", 16'(wrap_w), 16'h0);
      load = 1'b1; load_bin = 3'd6;
      @(posedge clk);
      #1;
      check("mid_hold_bin", 16'(bin_w), 16'h0);
      #3;
      rst = 1'b0; load = 1'b0;
      step();
      check("mid_rel_gray", 16'(gray_w), 16'h1);
      check("mid_rel_wrap", 16'(wrap_w), 16'h0);
      en = 1'b0;

`ifdef GRAY_COUNTER_UPDOWN_EN
      // down-count through the wrap point
      dir = 1'b0;
      do_reset();
      check("dn_rst_tc", 16'(tc_w), 16'h1);
      en = 1'b1;
      step();
      check("dn_bin7", 16'(bin_w), 16'h7);
      check("dn_gray7", 16'(gray_w), 16'h4);
      check("dn_wrap7", 16'(wrap_w), 16'h1);
      step();
      check("dn_bin6", 16'(bin_w), 16'h6);
      check("dn_gray6", 16'(gray_w), 16'h5);
      check("dn_wrap6", 16'(wrap_w), 16'h0);
      step();
      check("dn_bin5", 16'(bin_w), 16'h5);
      check("dn_gray5", 16'(gray_w), 16'h7);
      en = 1'b0; dir = 1'b1;
`endif

      // random run against the model and the Gray-to-binary round trip
      do_reset();
      eb_w = '0; eb_s = '0;
      for (int c = 0; c < 1000; c++) begin
         e = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 7) == 0);
         lb = W'($urandom_range(0, 7));
`ifdef GRAY_COUNTER_UPDOWN_EN
         d = ($urandom_range(0, 1) == 1);
`else
         d = 1'b1;
`endif
         en = e; load = l; load_bin = lb; dir = d;
         nx_w = model(eb_w, e, l, lb, d, 1'b0);
         nx_s = model(eb_s, e, l, lb, d, 1'b1);
         exp_q.push_back(nx_w);
         sat_q.push_back(nx_s);
         prev_w = eb_w;
         step();
         got = exp_q.pop_front();
         eb_w = got[W-1:0];
         check("rnd_bin", 16'(bin_w), 16'(eb_w));
         check("rnd_roundtrip", 16'(g2b(gray_w)), 16'(eb_w));
         check("rnd_wrap", 16'(wrap_w), 16'(got[W]));
         tc_exp = d ? (eb_w == MAXV) : (eb_w == '0);
         check("rnd_tc", 16'(tc_w), 16'(tc_exp));
         if (!l && eb_w != prev_w)
            check("rnd_onebit", 16'($countones(gray_w ^ to_gray(prev_w))), 16'h1);
         got = sat_q.pop_front();
         eb_s = got[W-1:0];
         check("rnd_sat_bin", 16'(bin_s), 16'(eb_s));
         check("rnd_sat_roundtrip", 16'(g2b(gray_s)), 16'(eb_s));
         check("rnd_sat_wrap", 16'(wrap_s), 16'h0);
      end
      en = 1'b0; load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
